// File: rtl/trig_seq.sv
`default_nettype none
// ============================================================================
// Module   : trig_seq
// Brief    : Burst trigger sequencer - N pulses of W cycles, P cycles apart.
// Revision : 1.0
// ============================================================================
module trig_seq #(
    parameter int PER_W = 32,
    parameter int WID_W = 20,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PER_W-1:0] period,
    input  logic [WID_W-1:0] width,
    input  logic [CNT_W-1:0] burst,
    output logic             trig,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    // Wide enough to hold W+1 without truncation before the period clamp.
    localparam int EXT_W = ((PER_W > WID_W) ? PER_W : WID_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_enter_high;

    logic               r_trig;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;
    logic [WID_W-1:0]   r_wcnt;
    logic [PER_W-1:0]   r_pcnt;
    logic [WID_W-1:0]   r_w;
    logic [EXT_W-1:0]   r_p;
    logic [CNT_W-1:0]   r_n;

    logic [WID_W-1:0]   w_w;
    logic [EXT_W-1:0]   w_w_plus1;
    logic [EXT_W-1:0]   w_period_ext;
    logic [EXT_W-1:0]   w_p;

    // Effective configuration: W >= 1 and P >= W+1 so every LOW phase is non-empty.
    always_comb begin
        w_w          = (width == '0) ? WID_W'(1) : width;
        w_w_plus1    = {{(EXT_W-WID_W){1'b0}}, w_w} + EXT_W'(1);
        w_period_ext = {{(EXT_W-PER_W){1'b0}}, period};
        w_p          = (w_period_ext < w_w_plus1) ? w_w_plus1 : w_period_ext;
    end

    assign w_accept = (r_state == S_IDLE) && start && !abort;

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_high = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (burst == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt  = S_HIGH;
                        w_enter_high = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (r_wcnt == r_w) begin
                    w_state_nxt = (r_cnt < r_n) ? S_LOW : S_DONE;
                end
            end
            S_LOW: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if ({{(EXT_W-PER_W){1'b0}}, r_pcnt} == r_p) begin
                    w_state_nxt  = S_HIGH;
                    w_enter_high = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_trig  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_pcnt  <= '0;
            r_w     <= '0;
            r_p     <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_trig  <= (w_state_nxt == S_HIGH);
            r_done  <= (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_w   <= w_w;
                r_p   <= w_p;
                r_n   <= burst;
                r_cnt <= '0;
            end

            // Both counters restart at 1 on each rising edge of trig.
            if (w_enter_high) begin
                r_cnt  <= (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
                r_wcnt <= WID_W'(1);
                r_pcnt <= PER_W'(1);
            end else if (r_state == S_HIGH || r_state == S_LOW) begin
                if (r_state == S_HIGH) begin
                    r_wcnt <= r_wcnt + WID_W'(1);
                end
                r_pcnt <= r_pcnt + PER_W'(1);
            end
        end
    end

    assign trig      = r_trig;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);
    assign pulse_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trig_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_seq
// Brief    : Directed self-checking bench for trig_seq.
// Revision : 1.0
// ============================================================================
module tb_trig_seq;

    localparam int PER_W = 32;
    localparam int WID_W = 20;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [PER_W-1:0] period;
    logic [WID_W-1:0] width;
    logic [CNT_W-1:0] burst;
    logic             trig;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    trig_seq #(.PER_W(PER_W), .WID_W(WID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .period    (period),
        .width     (width),
        .burst     (burst),
        .trig      (trig),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs set before this are sampled at that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        period = 32'd10; width = 20'd3; burst = 8'd4;
        step(); step();
        n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig got=%b exp=0", trig); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (pulse_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", pulse_cnt); end
        rst = 1'b0; start = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic e_t;
        period = 32'd10; width = 20'd3; burst = 8'd4;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            e_t = (k <= 33) && (((k - 1) % 10) < 3);
            n_checks++; if (trig !== e_t) begin n_fail++; $display("FAIL basic_trig k=%0d got=%b exp=%b", k, trig, e_t); end
            n_checks++; if (done !== (k == 34)) begin n_fail++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done, k == 34); end
            n_checks++; if (busy !== (k <= 34)) begin n_fail++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, busy, k <= 34); end
            if (k == 35) begin
                n_checks++; if (pulse_cnt !== 8'd4) begin n_fail++; $display("FAIL basic_cnt got=%0d exp=4", pulse_cnt); end
            end
            step();
        end
    endtask

    task automatic test_min_cfg();
        period = 32'd0; width = 20'd0; burst = 8'd2;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_checks++; if (trig !== (k == 1 || k == 3)) begin n_fail++; $display("FAIL min_trig k=%0d got=%b exp=%b", k, trig, (k == 1 || k == 3)); end
            n_checks++; if (done !== (k == 4)) begin n_fail++; $display("FAIL min_done k=%0d got=%b exp=%b", k, done, k == 4); end
            n_checks++; if (busy !== (k <= 4)) begin n_fail++; $display("FAIL min_busy k=%0d got=%b exp=%b", k, busy, k <= 4); end
            step();
        end
        n_checks++; if (pulse_cnt !== 8'd2) begin n_fail++; $display("FAIL min_cnt got=%0d exp=2", pulse_cnt); end
    endtask

    task automatic test_zero_burst();
        period = 32'd10; width = 20'd3; burst = 8'd0;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL zero_trig k=%0d got=%b exp=0", k, trig); end
            n_checks++; if (done !== (k == 1)) begin n_fail++; $display("FAIL zero_done k=%0d got=%b exp=%b", k, done, k == 1); end
            n_checks++; if (busy !== (k == 1)) begin n_fail++; $display("FAIL zero_busy k=%0d got=%b exp=%b", k, busy, k == 1); end
            n_checks++; if (pulse_cnt !== 8'd0) begin n_fail++; $display("FAIL zero_cnt k=%0d got=%0d exp=0", k, pulse_cnt); end
            step();
        end
    endtask

    task automatic test_abort();
        logic e_t;
        period = 32'd10; width = 20'd3; burst = 8'd5;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            e_t = (k <= 3) || (k >= 11 && k <= 13);
            n_checks++; if (trig !== e_t) begin n_fail++; $display("FAIL abort_trig k=%0d got=%b exp=%b", k, trig, e_t); end
            if (k < 15) step();
        end
        abort = 1'b1; step(); abort = 1'b0;
        n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL abort_trig_after got=%b exp=0", trig); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_done got=%b exp=1", done); end
        n_checks++; if (pulse_cnt !== 8'd2) begin n_fail++; $display("FAIL abort_cnt got=%0d exp=2", pulse_cnt); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done_once got=%b exp=0", done); end
        n_checks++; if (pulse_cnt !== 8'd2) begin n_fail++; $display("FAIL abort_cnt_hold got=%0d exp=2", pulse_cnt); end
        abort = 1'b1; step(); abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_in_idle busy=%b done=%b exp=0/0", busy, done); end
        period = 32'd5; width = 20'd2; burst = 8'd1;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (trig !== (k <= 2)) begin n_fail++; $display("FAIL abort_restart_trig k=%0d got=%b exp=%b", k, trig, k <= 2); end
            n_checks++; if (done !== (k == 3)) begin n_fail++; $display("FAIL abort_restart_done k=%0d got=%b exp=%b", k, done, k == 3); end
            step();
        end
        n_checks++; if (pulse_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_restart_cnt got=%0d exp=1", pulse_cnt); end
    endtask

    task automatic test_start_ignored();
        logic e_t;
        period = 32'd6; width = 20'd2; burst = 8'd2;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            e_t = (k == 1 || k == 2 || k == 7 || k == 8);
            n_checks++; if (trig !== e_t) begin n_fail++; $display("FAIL ignore_trig k=%0d got=%b exp=%b", k, trig, e_t); end
            n_checks++; if (done !== (k == 9)) begin n_fail++; $display("FAIL ignore_done k=%0d got=%b exp=%b", k, done, k == 9); end
            n_checks++; if (busy !== (k <= 9)) begin n_fail++; $display("FAIL ignore_busy k=%0d got=%b exp=%b", k, busy, k <= 9); end
            start = (k == 3 || k == 8);
            if (k == 3) begin
                period = 32'd3; width = 20'd1; burst = 8'd9;
            end
            step();
        end
        start = 1'b0;
        n_checks++; if (pulse_cnt !== 8'd2) begin n_fail++; $display("FAIL ignore_cnt got=%0d exp=2", pulse_cnt); end
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || trig !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL start_abort_idle busy=%b trig=%b done=%b exp=0/0/0", busy, trig, done);
        end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle2 busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        period = 32'd4; width = 20'd2; burst = 8'd5;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            n_checks++; if (trig !== (((k - 1) % 4) < 2)) begin n_fail++; $display("FAIL rstmid_trig k=%0d got=%b exp=%b", k, trig, ((k - 1) % 4) < 2); end
            if (k < 9) step();
        end
        rst = 1'b1; step();
        n_checks++; if (trig !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pulse_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rstmid_outputs trig=%b busy=%b done=%b cnt=%0d exp=0/0/0/0", trig, busy, done, pulse_cnt);
        end
        rst = 1'b0; start = 1'b1; period = 32'd4; width = 20'd2; burst = 8'd1;
        step(); start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (trig !== (k <= 2)) begin n_fail++; $display("FAIL rstmid_new_trig k=%0d got=%b exp=%b", k, trig, k <= 2); end
            n_checks++; if (done !== (k == 3)) begin n_fail++; $display("FAIL rstmid_new_done k=%0d got=%b exp=%b", k, done, k == 3); end
            n_checks++; if (busy !== (k <= 3)) begin n_fail++; $display("FAIL rstmid_new_busy k=%0d got=%b exp=%b", k, busy, k <= 3); end
            step();
        end
        n_checks++; if (pulse_cnt !== 8'd1) begin n_fail++; $display("FAIL rstmid_new_cnt got=%0d exp=1", pulse_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_cfg();
        test_zero_burst();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trig_seq.md
TRIG_SEQ -- requirements
Module: trig_seq

Interface
REQ-001 Parameter PER_W, default 32: width of the period input and the period counter.
REQ-002 Parameter WID_W, default 20: width of the pulse-width input and the width counter.
REQ-003 Parameter CNT_W, default 8: width of the burst-count input and the pulse_cnt output.
REQ-004 Port clk, input, 1: single clock; every register is clocked on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle request to begin a burst.
REQ-007 Port abort, input, 1: terminates a burst in progress.
REQ-008 Port period, input, PER_W: cycles from one trig rising edge to the next.
REQ-009 Port width, input, WID_W: trig high time, in cycles.
REQ-010 Port burst, input, CNT_W: number of pulses in the burst.
REQ-011 Port trig, output, 1: registered trigger pulse output.
REQ-012 Port busy, output, 1: high while a burst is active.
REQ-013 Port done, output, 1: one-cycle pulse when a burst ends.
REQ-014 Port pulse_cnt, output, CNT_W: number of pulses issued in the current or last burst.

Function
REQ-015 FSM states SHALL be IDLE, HIGH, LOW and DONE; busy = (state != IDLE), decoded from registered state.
REQ-016 In IDLE, start=1 with abort=0 at edge t SHALL latch the configuration, clear pulse_cnt to 0 and enter HIGH at t+1; busy is high from t+1.
REQ-017 Latched config: W = max(width,1); P = max(period, W+1); N = burst. Inputs are ignored after latching.
REQ-018 Start with N=0 SHALL enter DONE directly: no trig pulse, done=1 at t+1, pulse_cnt stays 0.
REQ-019 On every entry to HIGH, pulse_cnt SHALL increment by 1 and trig SHALL be 1 for exactly W cycles.
REQ-020 After W cycles in HIGH: if pulse_cnt < N, go to LOW for exactly P-W cycles with trig=0, then HIGH again; if pulse_cnt == N, go to DONE.
REQ-021 Result: rising edges of trig occur exactly P cycles apart; the burst is N pulses long; there is no LOW phase after the last pulse.
REQ-022 DONE SHALL last exactly one cycle with done=1 and trig=0, then return to IDLE.
REQ-023 start received while not in IDLE SHALL be ignored, with no queuing.
REQ-024 abort=1 in HIGH or LOW SHALL enter DONE at the next edge: trig=0 at once, pulse_cnt holds its value, and done pulses once.
REQ-025 abort in IDLE or DONE SHALL have no effect; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-026 Counters SHALL never wrap: the period counter spans at most PER_W bits and the width counter at most WID_W bits, and the comparisons are exact.
REQ-027 pulse_cnt SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-028 rst=1 SHALL force the following at the next edge, overriding all other inputs: state=IDLE, trig=0, busy=0, done=0, pulse_cnt=0, all counters 0.
REQ-029 rst asserted mid-burst SHALL stop the burst without a done pulse.
REQ-030 The first start is accepted on the first edge after rst is released.

Verification
REQ-031 period=10, width=3, burst=4, start at t -> trig high at t+1..t+3, t+11..t+13, t+21..t+23, t+31..t+33; done at t+34; pulse_cnt=4; busy=0 from t+35.
REQ-032 width=0, period=0, burst=2 -> W=1 and P=2: trig high at t+1 and t+3; done at t+4.
REQ-033 burst=0 -> no trig pulse; done at t+1; pulse_cnt=0.
REQ-034 period=10, width=3, burst=5, abort during the LOW phase of pulse 2 -> trig stays 0; done one cycle later; pulse_cnt=2; a new start is accepted afterwards.
REQ-035 start re-pulsed mid-burst, and start+abort together in IDLE -> neither changes the timing or the state.
REQ-036 rst asserted during HIGH of pulse 3 -> next cycle all outputs 0 and no done pulse; a start after release gives a clean burst.
